// File: rtl/ether_payload_unpacker_if.sv
// Byte-stream input and address/pixel/drop outputs of the Ethernet payload unpacker.
// The unpacker takes the slave view; whatever feeds it and consumes its outputs takes the master view.
interface ether_payload_unpacker_if;
    logic        axiiv;
    logic [7:0]  axiid;
    logic        addr_axiov;
    logic [23:0] addr_axiod;
    logic        pixel_axiov;
    logic [7:0]  pixel_axiod;
    logic        drop_pulse;

    modport master (
        output axiiv, axiid,
        input  addr_axiov, addr_axiod, pixel_axiov, pixel_axiod, drop_pulse
    );

    modport slave (
        input  axiiv, axiid,
        output addr_axiov, addr_axiod, pixel_axiov, pixel_axiod, drop_pulse
    );
endinterface

// File: rtl/ether_payload_unpacker.sv
// Filters received frames by EtherType, extracts the 24-bit start address and forwards
// pixel bytes while holding back the trailing 4-byte FCS.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a frame start (rising edge of axiiv)
// S_HEADER | counting header bytes 1..13, checking EtherType at 12/13
// S_ADDR   | shifting in the three big-endian start address bytes
// S_PIXELS | pixel bytes pass through a 4-deep hold so the FCS never leaves
// S_DROP   | EtherType mismatch, discarding bytes until axiiv falls
module ether_payload_unpacker #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input logic                     clk,
    input logic                     rst,
    ether_payload_unpacker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_PIXELS,
        S_DROP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  byte_cnt, byte_cnt_nxt;
    logic        type_bad, type_bad_nxt;
    logic        prev_v;
    logic [15:0] addr_sr, addr_sr_nxt;
    logic [31:0] hold, hold_nxt;
    logic [2:0]  hold_cnt, hold_cnt_nxt;

    logic        addr_v, addr_v_nxt;
    logic [23:0] addr_d, addr_d_nxt;
    logic        pix_v, pix_v_nxt;
    logic [7:0]  pix_d, pix_d_nxt;
    logic        drop, drop_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            byte_cnt <= 4'd0;
            type_bad <= 1'b0;
            prev_v   <= 1'b1;
            addr_sr  <= 16'd0;
            hold     <= 32'd0;
            hold_cnt <= 3'd0;
            addr_v   <= 1'b0;
            addr_d   <= 24'd0;
            pix_v    <= 1'b0;
            pix_d    <= 8'd0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            type_bad <= type_bad_nxt;
            prev_v   <= bus.axiiv;
            addr_sr  <= addr_sr_nxt;
            hold     <= hold_nxt;
            hold_cnt <= hold_cnt_nxt;
            addr_v   <= addr_v_nxt;
            addr_d   <= addr_d_nxt;
            pix_v    <= pix_v_nxt;
            pix_d    <= pix_d_nxt;
            drop     <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        type_bad_nxt = type_bad;
        addr_sr_nxt  = addr_sr;
        hold_nxt     = hold;
        hold_cnt_nxt = hold_cnt;
        addr_v_nxt   = 1'b0;
        addr_d_nxt   = addr_d;
        pix_v_nxt    = 1'b0;
        pix_d_nxt    = pix_d;
        drop_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                // prev_v resets high, so a frame already running at reset release is skipped
                if (bus.axiiv && !prev_v) begin
                    state_nxt    = S_HEADER;
                    byte_cnt_nxt = 4'd1;
                    type_bad_nxt = 1'b0;
                end
            end

            S_HEADER: begin
                if (!bus.axiiv) begin
                    state_nxt    = S_IDLE;
                    byte_cnt_nxt = 4'd0;
                end else begin
                    byte_cnt_nxt = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd12 && bus.axiid != ETHERTYPE[15:8])
                        type_bad_nxt = 1'b1;
                    if (byte_cnt == 4'd13) begin
                        byte_cnt_nxt = 4'd0;
                        if (type_bad || bus.axiid != ETHERTYPE[7:0]) begin
                            state_nxt = S_DROP;
                            drop_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ADDR;
                        end
                    end
                end
            end

            S_ADDR: begin
                if (!bus.axiiv) begin
                    state_nxt    = S_IDLE;
                    byte_cnt_nxt = 4'd0;
                end else begin
                    addr_sr_nxt  = {addr_sr[7:0], bus.axiid};
                    byte_cnt_nxt = byte_cnt + 4'd1;
                    if (byte_cnt == 4'd2) begin
                        addr_d_nxt   = {addr_sr, bus.axiid};
                        addr_v_nxt   = 1'b1;
                        byte_cnt_nxt = 4'd0;
                        state_nxt    = S_PIXELS;
                    end
                end
            end

            S_PIXELS: begin
                if (!bus.axiiv) begin
                    // whatever is still held is the FCS
                    state_nxt    = S_IDLE;
                    hold_nxt     = 32'd0;
                    hold_cnt_nxt = 3'd0;
                end else begin
                    hold_nxt = {hold[23:0], bus.axiid};
                    if (hold_cnt == 3'd4) begin
                        pix_v_nxt = 1'b1;
                        pix_d_nxt = hold[31:24];
                    end else begin
                        hold_cnt_nxt = hold_cnt + 3'd1;
                    end
                end
            end

            S_DROP: begin
                if (!bus.axiiv)
                    state_nxt = S_IDLE;
            end

            default: begin
                state_nxt    = S_IDLE;
                byte_cnt_nxt = 4'd0;
                hold_nxt     = 32'd0;
                hold_cnt_nxt = 3'd0;
            end
        endcase
    end

    assign bus.addr_axiov  = addr_v;
    assign bus.addr_axiod  = addr_d;
    assign bus.pixel_axiov = pix_v;
    assign bus.pixel_axiod = pix_d;
    assign bus.drop_pulse  = drop;

endmodule
